// File: rtl/fnv_pkg.sv
// fnv_pkg: FNV-1a constants, state encoding and the shift-add term list.
package fnv_pkg;
  localparam logic [31:0] FNV_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME = 32'h01000193;
  localparam int FNV_TERMS = 6;
  typedef enum logic [1:0] {IDLE, FETCH, MUL, EMIT} state_t;
  // i-th shifted copy of h; FNV_PRIME = 1 + 2 + 16 + 128 + 256 + 2^24
  function automatic logic [31:0] fnv_term(input logic [31:0] h, input logic [2:0] i);
    return i == 3'd0 ? h : i == 3'd1 ? h << 1 : i == 3'd2 ? h << 4 :
           i == 3'd3 ? h << 7 : i == 3'd4 ? h << 8 : h << 24;
  endfunction
endpackage

// File: rtl/fnv1a_step.sv
// fnv1a_step: one combinational FNV-1a byte step, (hash ^ byte) * PRIME by shift-add.
module fnv1a_step
  import fnv_pkg::*;
(
  input  logic [31:0] hash,
  input  logic [7:0]  data,
  output logic [31:0] next_hash
);
  logic [31:0] x;
  always_comb begin
    x = hash ^ {24'b0, data};
    next_hash = '0;
    for (int i = 0; i < FNV_TERMS; i++) next_hash = next_hash + fnv_term(x, 3'(i));
  end
endmodule

// File: rtl/fnv1a_hasher_fsm.sv
// fnv1a_hasher_fsm: pops length-prefixed messages, pushes their 32-bit FNV-1a hash.
// Define FNV_SERIAL_MUL_EN to spread each multiply over six MUL cycles.
module fnv1a_hasher_fsm
  import fnv_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic        system_clk,
  input  logic        rst_n,
  input  logic [7:0]  rdata,
  input  logic        rempty,
  output logic        rinc,
  output logic [31:0] wdata,
  input  logic        wfull,
  output logic        winc,
  output logic        busy
);
  state_t state;
  logic [31:0] hash;
  logic [LEN_WIDTH-1:0] remaining;
  assign rinc = rst_n && !rempty && (state == IDLE || state == FETCH);
  assign winc = rst_n && !wfull && state == EMIT;
`ifdef FNV_SERIAL_MUL_EN
  logic [31:0] opnd, term;
  logic [2:0] cnt;
  assign term = fnv_term(opnd, cnt);
`else
  logic [31:0] step;
  fnv1a_step u_step (.hash(hash), .data(rdata), .next_hash(step));
`endif
  always_ff @(posedge system_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hash <= FNV_OFFSET_BASIS;
      remaining <= '0;
      wdata <= '0;
      busy <= 1'b0;
`ifdef FNV_SERIAL_MUL_EN
      opnd <= '0;
      cnt <= '0;
`endif
    end else
      case (state)
        IDLE: if (!rempty) begin
          remaining <= LEN_WIDTH'(rdata);
          state <= rdata == 8'd0 ? EMIT : FETCH;
          if (rdata == 8'd0) wdata <= hash;
          busy <= 1'b1;
        end
`ifdef FNV_SERIAL_MUL_EN
        FETCH: if (!rempty) begin
          opnd <= hash ^ {24'b0, rdata};
          hash <= '0;
          cnt <= '0;
          remaining <= remaining - 1'b1;
          state <= MUL;
        end
        MUL: begin
          hash <= hash + term;
          cnt <= cnt + 1'b1;
          if (cnt == 3'(FNV_TERMS - 1)) begin
            state <= remaining == '0 ? EMIT : FETCH;
            if (remaining == '0) wdata <= hash + term;
          end
        end
`else
        FETCH: if (!rempty) begin
          hash <= step;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_WIDTH'(1)) begin
            state <= EMIT;
            wdata <= step;
          end
        end
`endif
        EMIT: if (!wfull) begin
          state <= IDLE;
          busy <= 1'b0;
          hash <= FNV_OFFSET_BASIS;
        end
        default: state <= IDLE;
      endcase
endmodule
